// File: rtl/transposition_pkg.sv
// Shared types and constants for the transposition-array sequencer.
package transposition_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } trans_state_e;

  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;
  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

endpackage

// File: rtl/transposition_perf_cnt.sv
// Saturating event counter with synchronous clear.
module transposition_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/transposition_ctrl.sv
// Load/drain sequencer for the transposition register array.
// Optional TRANSPOSITION_CTRL_PERF_EN adds tile and abort counters.
module transposition_ctrl
  import transposition_pkg::*;
#(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int CNT_WIDTH      = $clog2(SYSTOLIC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 tile_dir,
  output logic                 mode,
  output logic                 dir,
  output logic                 rst_sync,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] out_idx,
  output logic                 busy,
  output logic                 err
`ifdef TRANSPOSITION_CTRL_PERF_EN
  ,
  output logic [31:0]          tile_cnt,
  output logic [31:0]          abort_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(SYSTOLIC_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  trans_state_e         state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dir_q;
  logic                 abort;
  logic                 underrun;

  assign abort    = rst | flush;
  assign underrun = (state == LOAD) && !in_valid && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= DIR_UP;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dir_q <= tile_dir;
            cnt   <= ONE;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!in_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DRAIN: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake qualifiers are suppressed in any cycle that clears the array.
  assign in_ready  = !abort && (state != DRAIN);
  assign out_valid = !abort && (state == DRAIN);
  assign out_last  = out_valid && (cnt == LAST);
  assign out_idx   = (state == DRAIN) ? cnt : '0;
  assign mode      = (state == DRAIN) ? MODE_SHIFT : MODE_LOAD;
  assign dir       = dir_q;
  assign busy      = (state != IDLE);
  assign err       = underrun;
  assign rst_sync  = abort | underrun;

`ifdef TRANSPOSITION_CTRL_PERF_EN
  logic tile_done;
  logic abort_evt;

  assign tile_done = out_last;
  assign abort_evt = underrun || (flush && !rst && (state != IDLE));

  transposition_perf_cnt #(.WIDTH(32)) u_tile_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (tile_done),
    .count (tile_cnt)
  );

  transposition_perf_cnt #(.WIDTH(32)) u_abort_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (abort_evt),
    .count (abort_cnt)
  );
`endif

endmodule

// File: tb/tb_transposition_ctrl.sv
// Self-checking bench for transposition_ctrl: vector table, corner sequences, random vs. model.
module tb_transposition_ctrl;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, tile_dir;
  logic       in_ready, mode, dir, rst_sync, out_valid, out_last, busy, err;
  logic [1:0] out_idx;
`ifdef TRANSPOSITION_CTRL_PERF_EN
  logic [31:0] tile_cnt, abort_cnt;
`endif

  always #5 clk = ~clk;

  transposition_ctrl #(.SYSTOLIC_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tile_dir  (tile_dir),
    .mode      (mode),
    .dir       (dir),
    .rst_sync  (rst_sync),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy),
    .err       (err)
`ifdef TRANSPOSITION_CTRL_PERF_EN
    ,
    .tile_cnt  (tile_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: cycles elapsed since the first beat was accepted (-1 when idle).
  int   phase   = -1;
  logic dir_m   = 1'b0;
  int   m_tiles = 0;
  int   m_abort = 0;

  typedef struct {
    logic r, f, v, d;
    logic ir, ov, ol;
    logic [1:0] idx;
    logic er, bz, dr, rs;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic r, f, v, d, ir, ov, ol, input logic [1:0] idx,
                              input logic er, bz, dr, rs);
    vec_t x;
    x.r = r; x.f = f; x.v = v; x.d = d;
    x.ir = ir; x.ov = ov; x.ol = ol; x.idx = idx;
    x.er = er; x.bz = bz; x.dr = dr; x.rs = rs;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic f, input logic v, input logic d);
    rst = r; flush = f; in_valid = v; tile_dir = d;
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      m_tiles = 0;
      m_abort = 0;
    end else begin
      if (!flush && phase == 2*W-1) m_tiles++;
      if ((flush && phase != -1) || (!flush && phase >= 1 && phase < W && !in_valid)) m_abort++;
    end
    if (rst) begin
      phase = -1;
      dir_m = 1'b0;
    end else if (flush) begin
      phase = -1;
    end else if (phase == -1) begin
      if (in_valid) begin
        phase = 1;
        dir_m = tile_dir;
      end
    end else if (phase < W) begin
      phase = in_valid ? phase + 1 : -1;
    end else begin
      phase = (phase == 2*W-1) ? -1 : phase + 1;
    end
    #1;
  endtask

  task automatic check_model();
    logic ab, loading, draining, e_ov, e_err;
    ab       = rst | flush;
    loading  = (phase >= 1) && (phase < W);
    draining = (phase >= W);
    e_ov     = !ab && draining;
    e_err    = !ab && loading && !in_valid;
    chk("m_in_ready",  32'(in_ready),  32'(!ab && !draining));
    chk("m_out_valid", 32'(out_valid), 32'(e_ov));
    chk("m_out_last",  32'(out_last),  32'(e_ov && phase == 2*W-1));
    chk("m_out_idx",   32'(out_idx),   draining ? 32'(phase - W) : 32'd0);
    chk("m_err",       32'(err),       32'(e_err));
    chk("m_rst_sync",  32'(rst_sync),  32'(ab || e_err));
    chk("m_mode",      32'(mode),      32'(draining));
    chk("m_busy",      32'(busy),      32'(phase != -1));
    chk("m_dir",       32'(dir),       32'(dir_m));
`ifdef TRANSPOSITION_CTRL_PERF_EN
    chk("m_tile_cnt",  tile_cnt,       32'(m_tiles));
    chk("m_abort_cnt", abort_cnt,      32'(m_abort));
`endif
  endtask

  initial begin
    int lows, lasts, rows;

    //               r  f  v  d   ir ov ol idx er bz dr rs
    tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 1, 1,  1, 0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0,  1, 0, 0, 0,  0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0,  1, 0, 0, 0,  0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0,  1, 0, 0, 0,  0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0, 1, 0, 0,  0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0,  0, 1, 0, 1,  0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0, 1, 0, 2,  0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0,  0, 1, 1, 3,  0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0,  1, 0, 0, 0,  0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0);

    apply(1, 0, 0, 0);
    commit();

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d);
      chk($sformatf("t%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("t%0d_out_last", i),  32'(out_last),  32'(tbl[i].ol));
      chk($sformatf("t%0d_out_idx", i),   32'(out_idx),   32'(tbl[i].idx));
      chk($sformatf("t%0d_err", i),       32'(err),       32'(tbl[i].er));
      chk($sformatf("t%0d_busy", i),      32'(busy),      32'(tbl[i].bz));
      chk($sformatf("t%0d_dir", i),       32'(dir),       32'(tbl[i].dr));
      chk($sformatf("t%0d_rst_sync", i),  32'(rst_sync),  32'(tbl[i].rs));
      commit();
    end

    // Flush at drain index 1 with a simultaneous beat offered.
    for (int i = 0; i < W; i++) begin
      apply(0, 0, 1, 0);
      commit();
    end
    apply(0, 0, 0, 0);
    chk("fl_drain0_valid", 32'(out_valid), 32'd1);
    commit();
    apply(0, 1, 1, 0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_rst_sync",  32'(rst_sync),  32'd1);
    chk("fl_in_ready",  32'(in_ready),  32'd0);
    chk("fl_err",       32'(err),       32'd0);
    commit();
    apply(0, 0, 0, 0);
    chk("fl_no_accept_busy", 32'(busy), 32'd0);
    commit();

    // Continuous in_valid: two full tiles in 2*2W cycles.
    lows = 0; lasts = 0; rows = 0;
    for (int i = 0; i < 4*W; i++) begin
      apply(0, 0, 1, 1'(i / (2*W)));
      if (!in_ready) lows++;
      if (out_valid) rows++;
      if (out_last) lasts++;
      commit();
    end
    chk("b2b_ready_low", 32'(lows),  32'(2*W));
    chk("b2b_rows",      32'(rows),  32'(2*W));
    chk("b2b_lasts",     32'(lasts), 32'd2);
    chk("b2b_idle_end",  32'(busy),  32'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 1000; i++) begin
      apply(1'($urandom_range(0, 99) < 1), 1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 88), 1'($urandom));
      check_model();
      commit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
